// File: rtl/peridot_board_eeprom_reader.sv
// I2C EEPROM sequential reader: S devsel(W) addr Sr devsel(R) n*byte P.
// Open-drain lines via *_o (0 = pull low, 1 = release) and *_i readback.
module peridot_board_eeprom_reader #(
  parameter logic [6:0] I2C_DEV_ADDRESS = 7'b1010000,
  parameter int         CLOCK_DIV       = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byteaddr,
  input  logic [4:0] bytecount,
  output logic       busy,
  output logic [7:0] rddata,
  output logic       rddata_valid,
  output logic       done,
  output logic       error,
  input  logic       i2c_scl_i,
  input  logic       i2c_sda_i,
  output logic       i2c_scl_o,
  output logic       i2c_sda_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_DEVSEL_W = 3'd2;
  localparam logic [2:0] S_SETADDR  = 3'd3;
  localparam logic [2:0] S_REPSTART = 3'd4;
  localparam logic [2:0] S_DEVSEL_R = 3'd5;
  localparam logic [2:0] S_READBYTE = 3'd6;
  localparam logic [2:0] S_STOP     = 3'd7;

  localparam logic [9:0] DIV_LAST = 10'(CLOCK_DIV - 1);
  localparam logic [9:0] DIV_MID  = 10'(CLOCK_DIV / 2);

  logic [2:0] state;
  logic [1:0] phase;
  logic [9:0] cnt;
  logic [3:0] bitcnt;
  logic [7:0] tx;
  logic [6:0] rx;
  logic [7:0] addr_q;
  logic [5:0] remain;
  logic       scl_d, sda_d;
  logic       stretch, tick, mid;
  logic       last_bit, xmit;

  assign xmit     = (state == S_DEVSEL_W) || (state == S_SETADDR) ||
                    (state == S_DEVSEL_R);
  // SCL-high phase holds its counter while the target stretches
  assign stretch  = (phase == 2'd2) && !i2c_scl_i;
  assign tick     = !stretch && (cnt == DIV_LAST);
  assign mid      = !stretch && (phase == 2'd2) && (cnt == DIV_MID);
  assign last_bit = (bitcnt == 4'd8);
  assign busy     = (state != S_IDLE);

  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    unique case (1'b1)
      (state == S_IDLE): begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
      (state == S_START),
      (state == S_REPSTART): begin
        scl_d = phase[0] ^ phase[1];
        sda_d = !phase[1];
      end
      (state == S_STOP): begin
        scl_d = (phase != 2'd0);
        sda_d = phase[1];
      end
      xmit: begin
        scl_d = phase[0] ^ phase[1];
        sda_d = last_bit ? 1'b1 : tx[7];
      end
      (state == S_READBYTE): begin
        scl_d = phase[0] ^ phase[1];
        sda_d = last_bit ? (remain == 6'd1) : 1'b1;
      end
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      phase        <= 2'd0;
      cnt          <= '0;
      bitcnt       <= '0;
      tx           <= '0;
      rx           <= '0;
      addr_q       <= '0;
      remain       <= '0;
      rddata       <= '0;
      rddata_valid <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      i2c_scl_o    <= 1'b1;
      i2c_sda_o    <= 1'b1;
    end else begin
      done         <= 1'b0;
      rddata_valid <= 1'b0;
      i2c_scl_o    <= scl_d;
      i2c_sda_o    <= sda_d;
      if (state == S_IDLE) begin
        cnt    <= '0;
        phase  <= 2'd0;
        bitcnt <= '0;
        if (start) begin
          state  <= S_START;
          phase  <= 2'd2;
          addr_q <= byteaddr;
          remain <= (bytecount == 5'd0) ? 6'd32 : {1'b0, bytecount};
          error  <= 1'b0;
          tx     <= {I2C_DEV_ADDRESS, 1'b0};
        end
      end else begin
        cnt <= (stretch || tick) ? '0 : cnt + 10'd1;
        if (mid && state == S_READBYTE && !last_bit) begin
          rx <= {rx[5:0], i2c_sda_i};
          if (bitcnt == 4'd7) begin
            rddata       <= {rx, i2c_sda_i};
            rddata_valid <= 1'b1;
          end
        end
        if (mid && xmit && last_bit && i2c_sda_i)
          error <= 1'b1;
        if (tick) begin
          phase <= phase + 2'd1;
          if (phase == 2'd3) begin
            unique case (state)
              S_START: begin
                state  <= S_DEVSEL_W;
                bitcnt <= '0;
              end
              S_REPSTART: begin
                state  <= S_DEVSEL_R;
                bitcnt <= '0;
                tx     <= {I2C_DEV_ADDRESS, 1'b1};
              end
              S_STOP: begin
                state <= S_IDLE;
                done  <= 1'b1;
              end
              default: begin
                if (!last_bit) begin
                  bitcnt <= bitcnt + 4'd1;
                  tx     <= {tx[6:0], 1'b0};
                end else begin
                  bitcnt <= '0;
                  if (xmit && error)
                    state <= S_STOP;
                  else if (state == S_DEVSEL_W) begin
                    state <= S_SETADDR;
                    tx    <= addr_q;
                  end else if (state == S_SETADDR)
                    state <= S_REPSTART;
                  else if (state == S_DEVSEL_R)
                    state <= S_READBYTE;
                  else begin
                    remain <= remain - 6'd1;
                    if (remain == 6'd1)
                      state <= S_STOP;
                  end
                end
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_peridot_board_eeprom_reader.sv
// Directed bench: bus-level EEPROM target model on a wired-AND I2C bus.
// Checks strobes, master ACK/NACK, bus bytes, START/STOP and SDA stability.
module tb_peridot_board_eeprom_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] byteaddr = 8'h00;
  logic [4:0] bytecount = 5'd0;
  logic       busy, rddata_valid, done, error;
  logic [7:0] rddata;
  logic       scl_o, sda_o;
  logic       slv_scl = 1'b1;
  logic       slv_sda = 1'b1;
  wire        bus_scl = scl_o & slv_scl;
  wire        bus_sda = sda_o & slv_sda;

  peridot_board_eeprom_reader #(
    .I2C_DEV_ADDRESS(7'b1010000),
    .CLOCK_DIV(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .byteaddr(byteaddr),
    .bytecount(bytecount),
    .busy(busy),
    .rddata(rddata),
    .rddata_valid(rddata_valid),
    .done(done),
    .error(error),
    .i2c_scl_i(bus_scl),
    .i2c_sda_i(bus_sda),
    .i2c_scl_o(scl_o),
    .i2c_sda_o(sda_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] mem [256];
  logic [7:0] rd_q [$];
  logic [7:0] wr_q [$];
  logic       ack_q [$];
  int n_start = 0, n_stop = 0, n_edge = 0;
  int done_cnt = 0, stretch_cyc = 0;
  bit present = 1'b1;
  bit stretch_en = 1'b0;

  function automatic logic [7:0] rd_at(input int i);
    return (i < rd_q.size()) ? rd_q[i] : 8'hxx;
  endfunction

  function automatic logic [7:0] wr_at(input int i);
    return (i < wr_q.size()) ? wr_q[i] : 8'hxx;
  endfunction

  function automatic logic ack_at(input int i);
    return (i < ack_q.size()) ? ack_q[i] : 1'bx;
  endfunction

  localparam int M_IDLE = 0, M_ADDR = 1, M_WADDR = 2;
  localparam int M_WAIT = 3, M_READ = 4;

  // target model: acts on bus edges seen at the falling clk edge
  int         mode = M_IDLE, nxt = M_IDLE, bitn = 0, st_cnt = 0;
  logic [7:0] sh = 8'h00, ptr = 8'h00;
  logic       mack = 1'b0, p_scl = 1'b1, p_sda = 1'b1;
  logic       s_scl, s_sda;

  always @(negedge clk) begin
    s_scl = bus_scl;
    s_sda = bus_sda;
    if (!reset) begin
      mode = M_IDLE; bitn = 0; st_cnt = 0;
      slv_sda = 1'b1; slv_scl = 1'b1;
    end else begin
      if (st_cnt != 0) begin
        st_cnt--;
        if (st_cnt == 0) slv_scl = 1'b1;
      end
      if (p_scl && s_scl && p_sda && !s_sda) begin
        n_start++; mode = M_ADDR; bitn = 0; slv_sda = 1'b1;
      end else if (p_scl && s_scl && !p_sda && s_sda) begin
        n_stop++; mode = M_IDLE; slv_sda = 1'b1;
      end else if (!p_scl && s_scl) begin
        if (bitn < 8) sh = {sh[6:0], s_sda};
        if (bitn == 7 && (mode == M_ADDR || mode == M_WADDR))
          wr_q.push_back(sh);
        if (bitn == 8 && mode == M_READ) begin
          mack = s_sda; ack_q.push_back(s_sda);
        end
        bitn++;
      end else if (p_scl && !s_scl) begin
        if (bitn == 8) begin
          slv_sda = 1'b1; nxt = M_IDLE;
          if (mode == M_ADDR && present && sh[7:1] == 7'h50) begin
            slv_sda = 1'b0;
            nxt = sh[0] ? M_READ : M_WADDR;
            if (sh[0] && stretch_en) begin
              slv_scl = 1'b0; st_cnt = 50;
            end
          end else if (mode == M_WADDR) begin
            slv_sda = 1'b0; ptr = sh; nxt = M_WAIT;
          end
        end else if (bitn == 9) begin
          bitn = 0;
          if (mode == M_READ) begin
            if (mack) mode = M_IDLE;
            else ptr = ptr + 8'd1;
          end else mode = nxt;
          slv_sda = (mode == M_READ) ? mem[ptr][7] : 1'b1;
        end else if (mode == M_READ && bitn >= 1 && bitn <= 7) begin
          slv_sda = mem[ptr][7 - bitn];
        end
      end
    end
    p_scl = s_scl;
    p_sda = s_sda;
  end

  logic m_pscl = 1'b1, m_psda = 1'b1;

  always @(negedge clk) begin
    if (rddata_valid) rd_q.push_back(rddata);
    if (done) done_cnt++;
    if (scl_o && !bus_scl) stretch_cyc++;
    if (reset && m_pscl && bus_scl && m_psda != bus_sda) n_edge++;
    m_pscl = bus_scl;
    m_psda = bus_sda;
  end

  task automatic run_txn(input logic [7:0] a, input logic [4:0] n,
                         input bit inj, output logic got_err);
    int  t;
    bit  seen;
    @(negedge clk);
    byteaddr = a; bytecount = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0; byteaddr = ~a; bytecount = n + 5'd3;
    if (inj) begin
      repeat (40) @(negedge clk);
      byteaddr = 8'h99; bytecount = 5'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0; got_err = 1'bx; t = 0;
    while (!seen && t < 20000) begin
      @(posedge clk); #1; t++;
      if (done) begin
        seen = 1'b1; got_err = error;
        chk("busy_at_done", busy, 0);
      end
    end
    chk("done_seen", seen, 1);
    repeat (4) @(negedge clk);
  endtask

  int rb, wb, ab, sb, pb, eb, db, bad, t;
  logic e;

  task automatic mark();
    rb = rd_q.size(); wb = wr_q.size(); ab = ack_q.size();
    sb = n_start; pb = n_stop; eb = n_edge; db = done_cnt;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[8'h10] = 8'h4E; mem[8'h11] = 8'h01; mem[8'h12] = 8'hFF;

    repeat (3) @(negedge clk);
    chk("rst_scl", scl_o, 1);
    chk("rst_sda", sda_o, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", rddata_valid, 0);
    chk("rst_error", error, 0);
    chk("rst_rddata", rddata, 8'h00);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // basic 3-byte read
    mark();
    run_txn(8'h10, 5'd3, 1'b0, e);
    chk("t1_err", e, 0);
    chk("t1_nrd", rd_q.size() - rb, 3);
    chk("t1_d0", rd_at(rb), 8'h4E);
    chk("t1_d1", rd_at(rb + 1), 8'h01);
    chk("t1_d2", rd_at(rb + 2), 8'hFF);
    chk("t1_acks", {ack_at(ab), ack_at(ab + 1), ack_at(ab + 2)}, 3'b001);
    chk("t1_nwr", wr_q.size() - wb, 3);
    chk("t1_w0", wr_at(wb), 8'hA0);
    chk("t1_w1", wr_at(wb + 1), 8'h10);
    chk("t1_w2", wr_at(wb + 2), 8'hA1);
    chk("t1_starts", n_start - sb, 2);
    chk("t1_stops", n_stop - pb, 1);
    chk("t1_sda_hi_edges", n_edge - eb, 3);
    chk("t1_ndone", done_cnt - db, 1);
    chk("t1_busy_after", busy, 0);

    // no target present
    present = 1'b0;
    mark();
    run_txn(8'h10, 5'd3, 1'b0, e);
    chk("t2_err", e, 1);
    chk("t2_nrd", rd_q.size() - rb, 0);
    chk("t2_nwr", wr_q.size() - wb, 1);
    chk("t2_w0", wr_at(wb), 8'hA0);
    chk("t2_stops", n_stop - pb, 1);
    chk("t2_err_hold", error, 1);
    present = 1'b1;

    // bytecount 0 reads 32 bytes
    mark();
    run_txn(8'h40, 5'd0, 1'b0, e);
    chk("t3_err", e, 0);
    chk("t3_nrd", rd_q.size() - rb, 32);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      if (rd_at(rb + k) !== mem[8'(8'h40 + k)]) bad++;
      if (ack_at(ab + k) !== (k == 31)) bad++;
    end
    chk("t3_data_ack_bad", bad, 0);
    chk("t3_err_cleared", error, 0);

    // clock stretch in DEVSEL_R ack bit
    stretch_en = 1'b1;
    stretch_cyc = 0;
    mark();
    run_txn(8'h20, 5'd2, 1'b0, e);
    stretch_en = 1'b0;
    chk("t4_err", e, 0);
    chk("t4_d0", rd_at(rb), mem[8'h20]);
    chk("t4_d1", rd_at(rb + 1), mem[8'h21]);
    chk("t4_stretch", (stretch_cyc >= 38 && stretch_cyc <= 50), 1);
    chk("t4_sda_hi_edges", n_edge - eb, 3);

    // start while busy is ignored
    mark();
    run_txn(8'h30, 5'd2, 1'b1, e);
    repeat (200) @(negedge clk);
    chk("t5_err", e, 0);
    chk("t5_nrd", rd_q.size() - rb, 2);
    chk("t5_d0", rd_at(rb), mem[8'h30]);
    chk("t5_d1", rd_at(rb + 1), mem[8'h31]);
    chk("t5_w1", wr_at(wb + 1), 8'h30);
    chk("t5_ndone", done_cnt - db, 1);
    chk("t5_busy", busy, 0);

    // reset during the second byte
    mark();
    @(negedge clk);
    byteaddr = 8'h50; bytecount = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (rd_q.size() == rb && t < 5000) begin
      @(negedge clk); t++;
    end
    chk("t6_first_byte", rd_q.size() - rb, 1);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t6_scl", scl_o, 1);
    chk("t6_sda", sda_o, 1);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_rddata", rddata, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    chk("t6_no_done", done_cnt - db, 0);
    chk("t6_no_stop", n_stop - pb, 0);

    mark();
    run_txn(8'h60, 5'd1, 1'b0, e);
    chk("t7_err", e, 0);
    chk("t7_nrd", rd_q.size() - rb, 1);
    chk("t7_d0", rd_at(rb), mem[8'h60]);
    chk("t7_ack", ack_at(ab), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
